// File: rtl/aurora_link_supervisor.sv
// Aurora 64B/66B link supervisor.
// Qualifies channel/lane status, sequences reset-request/retry recovery,
// gates the TX AXI4-Stream at frame boundaries and keeps link statistics.
module aurora_link_supervisor #(
  parameter int NUM_LANES     = 2,
  parameter int HOLD_CYCLES   = 256,
  parameter int UP_TIMEOUT    = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int ERR_WINDOW    = 4096,
  parameter int ERR_THRESH    = 16,
  parameter int MAX_RETRY     = 8,
  parameter int CNT_W         = 16
) (
  input  logic                 user_clk,
  input  logic                 system_rst_n,
  input  logic                 channel_up,
  input  logic [NUM_LANES-1:0] lane_up,
  input  logic                 hard_err,
  input  logic                 soft_err,
  input  logic                 clear_fail,
  input  logic                 clear_stats,
  output logic                 reset_req,
  output logic                 link_ok,
  output logic                 link_fail,
  output logic [3:0]           retry_cnt,
  output logic [CNT_W-1:0]     soft_err_cnt,
  output logic [CNT_W-1:0]     link_drop_cnt,
  output logic                 frame_abort,
  input  logic                 s_tx_tvalid,
  output logic                 s_tx_tready,
  input  logic                 s_tx_tlast,
  output logic                 m_tx_tvalid,
  input  logic                 m_tx_tready,
  output logic                 m_tx_tlast
);

  // One shared timer covers HOLD, WAIT_UP and QUALIFY; size it for the longest.
  localparam int TMR_MAX0 = (HOLD_CYCLES > UP_TIMEOUT) ? HOLD_CYCLES : UP_TIMEOUT;
  localparam int TMR_MAX  = (TMR_MAX0 > STABLE_CYCLES) ? TMR_MAX0 : STABLE_CYCLES;
  localparam int TW       = $clog2(TMR_MAX + 1);
  localparam int WW       = $clog2(ERR_WINDOW + 1);
  localparam int BW       = $clog2(ERR_THRESH + 1);

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] UP_LAST     = TW'(UP_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(ERR_WINDOW - 1);
  localparam logic [BW-1:0] THRESH_V    = BW'(ERR_THRESH);

  typedef enum logic [2:0] {
    S_HOLD = 3'd0,
    S_WAIT = 3'd1,
    S_QUAL = 3'd2,
    S_UP   = 3'd3,
    S_FAIL = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tmr;
  logic [WW-1:0]   win_cnt;
  logic [BW-1:0]   burst_cnt;
  logic [BW-1:0]   burst_nxt;
  logic            win_wrap;
  logic            err_hit;
  logic            lanes_good;
  logic [3:0]      retry_inc;
  logic            retry_exhausted;
  logic            leave_up;
  logic            gate_open;
  logic            frame_open;
  logic            tx_acc;
  logic            reset_req_d, link_ok_d, link_fail_d;

  assign lanes_good      = channel_up & (&lane_up);
  assign retry_inc       = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
  assign retry_exhausted = {28'd0, retry_inc} >= 32'(MAX_RETRY);

  // A soft error landing in the wrap cycle belongs to the new window.
  assign win_wrap  = (win_cnt == WIN_LAST);
  assign burst_nxt = (win_wrap ? '0 : burst_cnt) + BW'(soft_err);
  assign err_hit   = (state == S_UP) && (burst_nxt >= THRESH_V);

  assign leave_up  = (state == S_UP) && (state_nxt != S_UP);

  // TX gate: pass-through only while the gate register is open.
  assign m_tx_tvalid = gate_open & s_tx_tvalid;
  assign s_tx_tready = gate_open & m_tx_tready;
  assign m_tx_tlast  = gate_open & s_tx_tlast;
  assign tx_acc      = s_tx_tvalid & s_tx_tready;

  // State register plus registered status outputs.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state     <= S_HOLD;
      reset_req <= 1'b1;
      link_ok   <= 1'b0;
      link_fail <= 1'b0;
    end else begin
      state     <= state_nxt;
      reset_req <= reset_req_d;
      link_ok   <= link_ok_d;
      link_fail <= link_fail_d;
    end
  end

  // Next-state decode; all UP drop causes collapse into one HOLD transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: if (tmr == HOLD_LAST) state_nxt = S_WAIT;
      S_WAIT: begin
        if (lanes_good)          state_nxt = S_QUAL;
        else if (tmr == UP_LAST) state_nxt = retry_exhausted ? S_FAIL : S_HOLD;
      end
      S_QUAL: begin
        if (!lanes_good)             state_nxt = S_WAIT;
        else if (tmr == STABLE_LAST) state_nxt = S_UP;
      end
      S_UP:   if (hard_err || !lanes_good || err_hit) state_nxt = S_HOLD;
      S_FAIL: if (clear_fail) state_nxt = S_HOLD;
      default: state_nxt = S_HOLD;
    endcase
  end

  // Output decode from the next state so the status flops align with the state.
  always_comb begin
    reset_req_d = (state_nxt == S_HOLD) || (state_nxt == S_FAIL);
    link_ok_d   = (state_nxt == S_UP);
    link_fail_d = (state_nxt == S_FAIL);
  end

  // Per-state timer, restarted on every state change.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n)                                 tmr <= '0;
    else if (state_nxt != state)                       tmr <= '0;
    else if (state == S_UP || state == S_FAIL)         tmr <= '0;
    else                                               tmr <= tmr + TW'(1);
  end

  // Consecutive failed attempts; cleared by a good link or by leaving FAIL.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n)
      retry_cnt <= 4'd0;
    else if (state == S_WAIT && (state_nxt == S_HOLD || state_nxt == S_FAIL))
      retry_cnt <= retry_inc;
    else if ((state == S_QUAL && state_nxt == S_UP) || (state == S_FAIL && state_nxt == S_HOLD))
      retry_cnt <= 4'd0;
  end

  // Soft-error burst window, running only while UP stays UP.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      win_cnt   <= '0;
      burst_cnt <= '0;
    end else if (state != S_UP || state_nxt != S_UP) begin
      win_cnt   <= '0;
      burst_cnt <= '0;
    end else begin
      win_cnt   <= win_wrap ? '0 : win_cnt + WW'(1);
      burst_cnt <= burst_nxt;
    end
  end

  // Saturating statistics; clear_stats wins over a same-cycle increment.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      soft_err_cnt  <= '0;
      link_drop_cnt <= '0;
    end else if (clear_stats) begin
      soft_err_cnt  <= '0;
      link_drop_cnt <= '0;
    end else begin
      if (soft_err && !(&soft_err_cnt))  soft_err_cnt  <= soft_err_cnt + CNT_W'(1);
      if (leave_up && !(&link_drop_cnt)) link_drop_cnt <= link_drop_cnt + CNT_W'(1);
    end
  end

  // Frame tracking and gate control; a beat taken in the last UP cycle still
  // counts toward the abort decision since it already reached the core.
  always_ff @(posedge user_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      frame_open  <= 1'b0;
      frame_abort <= 1'b0;
      gate_open   <= 1'b0;
    end else begin
      frame_abort <= leave_up && (tx_acc ? !s_tx_tlast : frame_open);
      if (leave_up)    frame_open <= 1'b0;
      else if (tx_acc) frame_open <= !s_tx_tlast;
      gate_open   <= (state_nxt == S_UP) && (gate_open || !frame_open);
    end
  end

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Directed bench for aurora_link_supervisor with hand-computed expectations.
module tb_aurora_link_supervisor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        channel_up, hard_err, soft_err, clear_fail, clear_stats;
  logic [1:0]  lane_up;
  logic        reset_req, link_ok, link_fail, frame_abort;
  logic [3:0]  retry_cnt;
  logic [15:0] soft_err_cnt, link_drop_cnt;
  logic        s_tx_tvalid, s_tx_tready, s_tx_tlast;
  logic        m_tx_tvalid, m_tx_tready, m_tx_tlast;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aurora_link_supervisor #(
    .NUM_LANES(2), .HOLD_CYCLES(4), .UP_TIMEOUT(100), .STABLE_CYCLES(8),
    .ERR_WINDOW(64), .ERR_THRESH(4), .MAX_RETRY(3), .CNT_W(16)
  ) dut (
    .user_clk(clk), .system_rst_n(rst_n),
    .channel_up(channel_up), .lane_up(lane_up), .hard_err(hard_err),
    .soft_err(soft_err), .clear_fail(clear_fail), .clear_stats(clear_stats),
    .reset_req(reset_req), .link_ok(link_ok), .link_fail(link_fail),
    .retry_cnt(retry_cnt), .soft_err_cnt(soft_err_cnt),
    .link_drop_cnt(link_drop_cnt), .frame_abort(frame_abort),
    .s_tx_tvalid(s_tx_tvalid), .s_tx_tready(s_tx_tready), .s_tx_tlast(s_tx_tlast),
    .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready), .m_tx_tlast(m_tx_tlast)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_link(input int budget);
    int n = 0;
    while (!link_ok && n < budget) begin
      tick(1);
      n++;
    end
    chk("link_up_in_budget", {31'd0, link_ok}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; channel_up = 1'b0; lane_up = 2'b00; hard_err = 1'b0;
    soft_err = 1'b0; clear_fail = 1'b0; clear_stats = 1'b0;
    s_tx_tvalid = 1'b0; s_tx_tlast = 1'b0; m_tx_tready = 1'b0;

    // Reset state, gate closed even with traffic offered
    tick(3);
    s_tx_tvalid = 1'b1; m_tx_tready = 1'b1;
    #1;
    chk("rst_reset_req", {31'd0, reset_req}, 32'd1);
    chk("rst_link_ok", {31'd0, link_ok}, 32'd0);
    chk("rst_link_fail", {31'd0, link_fail}, 32'd0);
    chk("rst_retry", {28'd0, retry_cnt}, 32'd0);
    chk("rst_soft_cnt", {16'd0, soft_err_cnt}, 32'd0);
    chk("rst_drop_cnt", {16'd0, link_drop_cnt}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tx_tvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, s_tx_tready}, 32'd0);
    s_tx_tvalid = 1'b0;
    rst_n = 1'b1;

    // Bring-up: 4 HOLD cycles, then QUALIFY for exactly 8 cycles
    tick(3);
    chk("hold_still_high", {31'd0, reset_req}, 32'd1);
    tick(1);
    chk("hold_released", {31'd0, reset_req}, 32'd0);
    channel_up = 1'b1; lane_up = 2'b11;
    tick(1);
    chk("qual_entry_ok", {31'd0, link_ok}, 32'd0);
    tick(7);
    chk("qual_last_ok", {31'd0, link_ok}, 32'd0);
    tick(1);
    chk("up_link_ok", {31'd0, link_ok}, 32'd1);
    chk("up_retry", {28'd0, retry_cnt}, 32'd0);

    // Soft-error window: 3 per window survives, 4 in one window drops the link
    for (int c = 0; c < 134; c++) begin
      if (c == 128) begin
        chk("win_3_stay_up", {31'd0, link_ok}, 32'd1);
        chk("win_soft_cnt6", {16'd0, soft_err_cnt}, 32'd6);
      end
      if (c == 133) chk("win_3rd_still_up", {31'd0, link_ok}, 32'd1);
      soft_err    = (c == 5 || c == 10 || c == 15 || c == 70 || c == 75 || c == 80 ||
                     (c >= 130 && c <= 133));
      clear_stats = (c == 128);
      tick(1);
    end
    soft_err = 1'b0; clear_stats = 1'b0;
    chk("win_4_drop", {31'd0, link_ok}, 32'd0);
    chk("win_reset_req", {31'd0, reset_req}, 32'd1);
    chk("win_drop_cnt", {16'd0, link_drop_cnt}, 32'd1);
    chk("win_soft_cnt4", {16'd0, soft_err_cnt}, 32'd4);

    // Frame abort: beat 1 accepted, channel lost while beat 2 is taken
    wait_link(40);
    s_tx_tvalid = 1'b1; s_tx_tlast = 1'b0; m_tx_tready = 1'b1;
    #1;
    chk("tx_pass_valid", {31'd0, m_tx_tvalid}, 32'd1);
    chk("tx_pass_ready", {31'd0, s_tx_tready}, 32'd1);
    tick(1);
    channel_up = 1'b0;
    tick(1);
    chk("abort_pulse", {31'd0, frame_abort}, 32'd1);
    chk("abort_m_tvalid", {31'd0, m_tx_tvalid}, 32'd0);
    chk("abort_s_tready", {31'd0, s_tx_tready}, 32'd0);
    chk("abort_drop_cnt", {16'd0, link_drop_cnt}, 32'd2);
    tick(1);
    chk("abort_single", {31'd0, frame_abort}, 32'd0);
    tick(3);
    chk("tail_blocked", {31'd0, s_tx_tready}, 32'd0);
    channel_up = 1'b1;
    wait_link(40);
    // New frame of two beats passes once the link is back
    s_tx_tlast = 1'b0;
    #1;
    chk("new_frame_valid", {31'd0, m_tx_tvalid}, 32'd1);
    tick(1);
    s_tx_tlast = 1'b1;
    #1;
    chk("new_frame_last", {31'd0, m_tx_tlast}, 32'd1);
    chk("new_frame_ready", {31'd0, s_tx_tready}, 32'd1);
    tick(1);
    s_tx_tvalid = 1'b0; s_tx_tlast = 1'b0;

    // Retry exhaustion with one lane stuck down; closed frame -> no abort
    lane_up = 2'b01;
    tick(1);
    chk("lane_drop_no_abort", {31'd0, frame_abort}, 32'd0);
    chk("lane_drop_cnt", {16'd0, link_drop_cnt}, 32'd3);
    tick(4);
    chk("retry_wait_req", {31'd0, reset_req}, 32'd0);
    tick(99);
    chk("retry_before_to", {28'd0, retry_cnt}, 32'd0);
    tick(1);
    chk("retry_after_to", {28'd0, retry_cnt}, 32'd1);
    chk("retry_rehold", {31'd0, reset_req}, 32'd1);
    tick(207);
    chk("fail_not_yet", {31'd0, link_fail}, 32'd0);
    tick(1);
    chk("fail_entered", {31'd0, link_fail}, 32'd1);
    chk("fail_retry3", {28'd0, retry_cnt}, 32'd3);
    tick(5);
    chk("fail_sticky", {31'd0, link_fail}, 32'd1);
    chk("fail_reset_req", {31'd0, reset_req}, 32'd1);
    clear_fail = 1'b1; lane_up = 2'b11;
    tick(1);
    clear_fail = 1'b0;
    chk("clr_fail_flag", {31'd0, link_fail}, 32'd0);
    chk("clr_fail_hold", {31'd0, reset_req}, 32'd1);
    chk("clr_fail_retry", {28'd0, retry_cnt}, 32'd0);

    // One-cycle lane glitch in QUALIFY restarts the stability count
    tick(4);
    chk("glitch_wait_req", {31'd0, reset_req}, 32'd0);
    tick(4);
    lane_up = 2'b01;
    tick(1);
    lane_up = 2'b11;
    tick(1);
    tick(3);
    chk("glitch_no_early_up", {31'd0, link_ok}, 32'd0);
    tick(4);
    chk("glitch_qual_last", {31'd0, link_ok}, 32'd0);
    tick(1);
    chk("glitch_up", {31'd0, link_ok}, 32'd1);

    // Coinciding drop causes count as a single drop
    hard_err = 1'b1; lane_up = 2'b01;
    tick(1);
    hard_err = 1'b0; lane_up = 2'b11;
    chk("multi_cause_down", {31'd0, link_ok}, 32'd0);
    chk("multi_cause_once", {16'd0, link_drop_cnt}, 32'd4);

    // Soft-error counter saturation
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    chk("stats_cleared", {16'd0, soft_err_cnt}, 32'd0);
    chk("drops_cleared", {16'd0, link_drop_cnt}, 32'd0);
    soft_err = 1'b1;
    tick(65535);
    chk("soft_reach_max", {16'd0, soft_err_cnt}, 32'h0000FFFF);
    tick(3);
    chk("soft_saturate", {16'd0, soft_err_cnt}, 32'h0000FFFF);
    soft_err = 1'b0;

    // Asynchronous reset mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_soft_cnt", {16'd0, soft_err_cnt}, 32'd0);
    chk("async_reset_req", {31'd0, reset_req}, 32'd1);
    chk("async_link_ok", {31'd0, link_ok}, 32'd0);
    chk("async_retry", {28'd0, retry_cnt}, 32'd0);
    tick(1);
    rst_n = 1'b1;

    // clear_stats beats a same-cycle soft error
    soft_err = 1'b1;
    tick(3);
    chk("soft_cnt3", {16'd0, soft_err_cnt}, 32'd3);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0; soft_err = 1'b0;
    chk("clear_over_inc", {16'd0, soft_err_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aurora_link_supervisor.md
Name: aurora_link_supervisor

Overview:
- Parametrised link supervisor for the multi-lane Aurora 64B/66B channel wrappers; sits on user_clk between the channel wrapper and the user AXI4-Stream TX logic.
- Qualifies channel/lane status and drives timed reset-request/retry recovery on timeout, hard error or soft-error burst.
- Gates TX AXI4-Stream at frame boundaries so partial frames never enter the core.
- Keeps saturating error and link-drop statistics.

Parameters:
NUM_LANES, 2, number of Aurora lanes (1..8); width of lane_up.
HOLD_CYCLES, 256, cycles reset_req is held high per recovery attempt (>=1).
UP_TIMEOUT, 65535, max cycles in WAIT_UP before retry (>=1).
STABLE_CYCLES, 1024, cycles channel_up and all lane_up must stay high before link_ok (>=1).
ERR_WINDOW, 4096, soft-error burst window length in cycles (>=1).
ERR_THRESH, 16, soft errors within one window that force recovery (>=1).
MAX_RETRY, 8, consecutive failed attempts before FAIL (>=1).
CNT_W, 16, width of statistics counters.

Ports:
user_clk  in  1  user clock from the channel clocking.
system_rst_n  in  1  asynchronous active-low reset; deasserted synchronously to user_clk upstream.
channel_up  in  1  channel status from wrapper.
lane_up  in  NUM_LANES  per-lane status.
hard_err  in  1  hard error level from wrapper.
soft_err  in  1  soft error, one count per high cycle.
clear_fail  in  1  single-cycle pulse: leave FAIL and restart recovery.
clear_stats  in  1  single-cycle pulse: zero statistics counters.
reset_req  out  1  drives wrapper system_rst / pma_init request.
link_ok  out  1  high only in state UP.
link_fail  out  1  high only in state FAIL.
retry_cnt  out  4  attempts since last successful UP (saturates at 15).
soft_err_cnt  out  CNT_W  total soft errors, saturating.
link_drop_cnt  out  CNT_W  UP->HOLD transitions, saturating.
frame_abort  out  1  one-cycle pulse: link lost while a TX frame was open.
s_tx_tvalid/s_tx_tready/s_tx_tlast  in/out/in  1 each  upstream TX handshake.
m_tx_tvalid/m_tx_tready/m_tx_tlast  out/in/out  1 each  toward wrapper; data/keep bypass externally.

Behaviour:
- Reset: state HOLD, hold counter 0, reset_req=1, link_ok=0, link_fail=0, frame_abort=0, all counters 0, frame-open flag 0, gate closed.
- HOLD: reset_req=1; after HOLD_CYCLES cycles -> WAIT_UP, timer cleared.
- WAIT_UP: reset_req=0; if channel_up && &lane_up -> QUALIFY; else at UP_TIMEOUT cycles -> retry_cnt+1, then FAIL if new retry_cnt >= MAX_RETRY, else HOLD.
- QUALIFY: any deassertion of channel_up or any lane_up -> WAIT_UP (timer restarts); STABLE_CYCLES consecutive good cycles -> UP, retry_cnt cleared.
- UP: link_ok=1 (registered, first high cycle = first cycle in UP). hard_err, channel_up low, any lane_up low, or window count reaching ERR_THRESH -> HOLD, link_drop_cnt+1.
- FAIL: reset_req=1, link_fail=1; stays until clear_fail -> HOLD, retry_cnt cleared.
- Priority in UP when causes coincide: all map to the same HOLD transition; counted once.
- Error window: free-running ERR_WINDOW counter, active only in UP; burst count cleared at window wrap and on entering UP. soft_err in wrap cycle counts toward new window.
- soft_err_cnt increments on every soft_err cycle in any state. clear_stats has priority over a same-cycle increment. Counters saturate at all-ones.
- TX gating: frame-open set on accepted beat with tlast=0, cleared on accepted tlast. Gate opens only when link_ok && !frame-open. It closes on leaving UP.
- While the gate is open: m_tx_tvalid=s_tx_tvalid, s_tx_tready=m_tx_tready, tlast passthrough (combinational).
- While the gate is closed: m_tx_tvalid=0, s_tx_tready=0.
- Leaving UP with frame-open=1 -> frame_abort pulses the next cycle and frame-open clears.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
- NUM_LANES=2, HOLD_CYCLES=4: release reset; channel_up and lane_up=2'b11 at cycle 10 -> reset_req low after 4 cycles, link_ok high exactly STABLE_CYCLES after entering QUALIFY, retry_cnt=0.
- Hold lane_up=2'b01, UP_TIMEOUT=100, MAX_RETRY=3 -> three HOLD/WAIT_UP cycles, retry_cnt=3, link_fail=1. clear_fail -> HOLD, retry_cnt=0.
- Drop lane_up[1] for 1 cycle mid-QUALIFY -> return to WAIT_UP; link_ok delayed by a full STABLE_CYCLES after recovery.
- In UP with ERR_WINDOW=64, ERR_THRESH=4: 3 soft_err per window -> stays UP. 4 within one window -> HOLD, link_drop_cnt=1, soft_err_cnt=4.
- Send a 5-beat frame; drop channel_up after beat 2 -> frame_abort single pulse, m_tx_tvalid=0. After re-UP, a new frame passes while the old tail is blocked until the link is back.
- soft_err_cnt at 16'hFFFF plus soft_err -> stays FFFF. clear_stats coinciding with soft_err -> 0.
